// File: rtl/cmul_sched_pkg.sv
// Shared types and widths for the time-shared complex multiplier.
// Four real products go through one MAC slice to form each complex product.
package cmul_sched_pkg;

    localparam int A_W    = 16;
    localparam int B_W    = 14;
    localparam int PROD_W = A_W + B_W;
    localparam int P_W    = A_W + B_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        S_RR,
        S_II,
        S_RI,
        S_IR,
        S_ACC
    } state_t;

    typedef enum logic [1:0] {
        SEL_RR,
        SEL_II,
        SEL_RI,
        SEL_IR
    } sel_t;

    typedef enum logic [1:0] {
        ACC_LOAD,
        ACC_ADD,
        ACC_SUB,
        ACC_HOLD
    } acc_op_t;

    function automatic logic signed [P_W-1:0] sext_prod(input logic signed [PROD_W-1:0] x);
        return P_W'(x);
    endfunction

endpackage

// File: rtl/cmul_mac_core.sv
// Single MAC slice: registered signed product (gated by cem) feeding an
// add/subtract accumulator. Pure datapath; sequencing lives in the caller.
module cmul_mac_core
    import cmul_sched_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    cem_i,
    input  logic signed [A_W-1:0]   a_i,
    input  logic signed [B_W-1:0]   b_i,
    input  acc_op_t                 acc_op_i,
    output logic signed [P_W-1:0]   m_o,
    output logic signed [P_W-1:0]   p_o
);

    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] m_q;
    logic signed [P_W-1:0]    m_ext;
    logic signed [P_W-1:0]    p_q;

    assign prod  = PROD_W'(a_i) * PROD_W'(b_i);
    assign m_ext = sext_prod(m_q);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m_q <= '0;
            p_q <= '0;
        end else begin
            if (cem_i) begin
                m_q <= prod;
            end
            case (acc_op_i)
                ACC_LOAD: p_q <= m_ext;
                ACC_ADD:  p_q <= p_q + m_ext;
                ACC_SUB:  p_q <= p_q - m_ext;
                default:  p_q <= p_q;
            endcase
        end
    end

    assign m_o = m_ext;
    assign p_o = p_q;

endmodule

// File: rtl/cmul_mac_sched.sv
// Complex multiplier controller: latches one sample/coefficient pair, runs
// four real multiplies through cmul_mac_core and presents the exact product.
//
// state | meaning
// IDLE  | waiting for accept (stalls here while a result is undrained)
// S_RR  | M <= a_re*b_re
// S_II  | M <= a_im*b_im, P <= M
// S_RI  | M <= a_re*b_im, P <= P -/+ M (real part complete in P)
// S_IR  | M <= a_im*b_re, RE_Q <= P, P <= M
// S_ACC | imag = M +/- P, publish result, OUT_VALID <= 1
module cmul_mac_sched
    import cmul_sched_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [A_W-1:0] a_re_in,
    input  logic signed [A_W-1:0] a_im_in,
    input  logic signed [B_W-1:0] b_re_in,
    input  logic signed [B_W-1:0] b_im_in,
    input  logic                  conj_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [P_W-1:0] p_re_out,
    output logic signed [P_W-1:0] p_im_out,
    output logic                  busy_out
);

    state_t                state_q, state_d;
    logic signed [A_W-1:0] a_re_q, a_im_q;
    logic signed [B_W-1:0] b_re_q, b_im_q;
    logic                  conj_q;
    logic signed [P_W-1:0] re_q;
    logic signed [P_W-1:0] p_re_q, p_im_q;
    logic                  out_valid_q;

    logic                  accept;
    logic                  cem;
    sel_t                  sel;
    acc_op_t               acc_op;
    logic signed [A_W-1:0] mac_a;
    logic signed [B_W-1:0] mac_b;
    logic signed [P_W-1:0] mac_m, mac_p;
    logic signed [P_W-1:0] im_sum;

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cem     = 1'b0;
        sel     = SEL_RR;
        acc_op  = ACC_HOLD;
        case (state_q)
            IDLE: begin
                if (accept) state_d = S_RR;
            end
            S_RR: begin
                cem     = 1'b1;
                sel     = SEL_RR;
                state_d = S_II;
            end
            S_II: begin
                cem     = 1'b1;
                sel     = SEL_II;
                acc_op  = ACC_LOAD;
                state_d = S_RI;
            end
            S_RI: begin
                cem     = 1'b1;
                sel     = SEL_RI;
                acc_op  = conj_q ? ACC_ADD : ACC_SUB;
                state_d = S_IR;
            end
            S_IR: begin
                cem     = 1'b1;
                sel     = SEL_IR;
                acc_op  = ACC_LOAD;
                state_d = S_ACC;
            end
            S_ACC: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mac_a = a_re_q;
        mac_b = b_re_q;
        case (sel)
            SEL_II: begin mac_a = a_im_q; mac_b = b_im_q; end
            SEL_RI: begin mac_a = a_re_q; mac_b = b_im_q; end
            SEL_IR: begin mac_a = a_im_q; mac_b = b_re_q; end
            default: begin mac_a = a_re_q; mac_b = b_re_q; end
        endcase
    end

    cmul_mac_core u_mac (
        .clk_i    (clk_in),
        .rst_n_i  (rst_n_in),
        .cem_i    (cem),
        .a_i      (mac_a),
        .b_i      (mac_b),
        .acc_op_i (acc_op),
        .m_o      (mac_m),
        .p_o      (mac_p)
    );

    // conj: imag = a_im*b_re - a_re*b_im, with a_re*b_im parked in P
    assign im_sum = conj_q ? (mac_m - mac_p) : (mac_m + mac_p);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            a_re_q      <= '0;
            a_im_q      <= '0;
            b_re_q      <= '0;
            b_im_q      <= '0;
            conj_q      <= 1'b0;
            re_q        <= '0;
            p_re_q      <= '0;
            p_im_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_re_q <= a_re_in;
                a_im_q <= a_im_in;
                b_re_q <= b_re_in;
                b_im_q <= b_im_in;
                conj_q <= conj_in;
            end
            if (state_q == S_IR) begin
                re_q <= mac_p;
            end
            if (state_q == S_ACC) begin
                p_re_q      <= re_q;
                p_im_q      <= im_sum;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign p_re_out  = p_re_q;
    assign p_im_out  = p_im_q;
    assign busy_out  = (state_q != IDLE);

endmodule

// File: tb/tb_cmul_mac_sched.sv
// Self-checking bench for cmul_mac_sched: directed cases plus random
// back-to-back traffic against a plain-arithmetic complex multiply model.
module tb_cmul_mac_sched;
    import cmul_sched_pkg::*;

    logic                  clk_in    = 1'b0;
    logic                  rst_n_in  = 1'b0;
    logic                  in_valid  = 1'b0;
    logic                  conj_in   = 1'b0;
    logic                  out_ready = 1'b0;
    logic signed [A_W-1:0] a_re_in   = '0;
    logic signed [A_W-1:0] a_im_in   = '0;
    logic signed [B_W-1:0] b_re_in   = '0;
    logic signed [B_W-1:0] b_im_in   = '0;
    logic                  in_ready, out_valid, busy_out;
    logic signed [P_W-1:0] p_re_out, p_im_out;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    cmul_mac_sched dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_re_in   (a_re_in),
        .a_im_in   (a_im_in),
        .b_re_in   (b_re_in),
        .b_im_in   (b_im_in),
        .conj_in   (conj_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p_re_out  (p_re_out),
        .p_im_out  (p_im_out),
        .busy_out  (busy_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic void ref_cmul(input int ar, input int ai, input int br,
                                     input int bi, input bit cj,
                                     output longint re, output longint im);
        longint rr, ii, ri, ir;
        rr = longint'(ar) * longint'(br);
        ii = longint'(ai) * longint'(bi);
        ri = longint'(ar) * longint'(bi);
        ir = longint'(ai) * longint'(br);
        if (cj) begin
            re = rr + ii;
            im = ir - ri;
        end else begin
            re = rr - ii;
            im = ri + ir;
        end
    endfunction

    // Returns #1 after the accepting edge.
    task automatic do_accept(input int ar, input int ai, input int br,
                             input int bi, input bit cj);
        int n;
        n = 0;
        a_re_in  = A_W'(ar);
        a_im_in  = A_W'(ai);
        b_re_in  = B_W'(br);
        b_im_in  = B_W'(bi);
        conj_in  = cj;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk_in); #1;
            n++;
        end
        chk("accept_ready", in_ready, 1);
        @(posedge clk_in); #1;
        in_valid = 1'b0;
        chk("accept_busy", busy_out, 1);
    endtask

    task automatic wait_result(input string tag, input longint er, input longint ei,
                               output int t_seen);
        int k, nb;
        k  = 0;
        nb = 0;
        do begin
            @(posedge clk_in); #1;
            k++;
            if (busy_out) nb++;
        end while (!out_valid && k < 20);
        chk({tag, "_latency"}, k, 5);
        chk({tag, "_busy_cycles"}, nb, 4);
        chk({tag, "_re"}, p_re_out, er);
        chk({tag, "_im"}, p_im_out, ei);
        t_seen = cyc;
    endtask

    task automatic run_tx(input string tag, input int ar, input int ai, input int br,
                          input int bi, input bit cj, input longint er, input longint ei);
        int t;
        do_accept(ar, ai, br, bi, cj);
        wait_result(tag, er, ei, t);
        @(posedge clk_in); #1;
        chk({tag, "_pulse"}, out_valid, 0);
    endtask

    initial begin
        longint er, ei, er2, ei2;
        int     t_prev, t_now, nstale;
        int     ar, ai, br, bi;
        bit     cj;

        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_p_re", p_re_out, 0);
        chk("rst_p_im", p_im_out, 0);
        chk("rst_busy", busy_out, 0);
        repeat (2) @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        out_ready = 1'b1;

        run_tx("basic", 3, 4, 5, 2, 1'b0, 7, 26);
        run_tx("conj", 3, 4, 5, 2, 1'b1, 23, 14);
        run_tx("extreme", -32768, -32768, -8192, 8191, 1'b0, 536838144, 32768);

        // Backpressure: result held, next transaction waits, then accepted on the drain edge
        out_ready = 1'b0;
        do_accept(3, 4, 5, 2, 1'b0);
        wait_result("bp_first", 7, 26, t_now);
        ref_cmul(-5, 12, 7, -3, 1'b1, er2, ei2);
        a_re_in  = A_W'(-5);
        a_im_in  = A_W'(12);
        b_re_in  = B_W'(7);
        b_im_in  = B_W'(-3);
        conj_in  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_in); #1;
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_re", p_re_out, 7);
            chk("bp_hold_im", p_im_out, 26);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_busy", busy_out, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk_in); #1;
        in_valid = 1'b0;
        chk("bp_drained", out_valid, 0);
        chk("bp_next_busy", busy_out, 1);
        wait_result("bp_second", er2, ei2, t_now);
        @(posedge clk_in); #1;
        chk("bp_second_pulse", out_valid, 0);

        // Reset in the middle of a transaction (in S_RI)
        do_accept(1000, -2000, 3000, -4000, 1'b0);
        @(posedge clk_in);
        @(posedge clk_in); #1;
        rst_n_in = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_p_re", p_re_out, 0);
        chk("midrst_p_im", p_im_out, 0);
        chk("midrst_busy", busy_out, 0);
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        nstale = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_in); #1;
            if (out_valid) nstale++;
        end
        chk("midrst_no_stale", nstale, 0);
        ref_cmul(100, -7, -3, 9, 1'b0, er, ei);
        run_tx("after_rst", 100, -7, -3, 9, 1'b0, er, ei);

        // Back-to-back random traffic, results one every 6 cycles
        t_prev = 0;
        for (int i = 0; i < 8; i++) begin
            ar = int'($urandom_range(65535)) - 32768;
            ai = int'($urandom_range(65535)) - 32768;
            br = int'($urandom_range(16383)) - 8192;
            bi = int'($urandom_range(16383)) - 8192;
            cj = 1'($urandom_range(1));
            ref_cmul(ar, ai, br, bi, cj, er, ei);
            do_accept(ar, ai, br, bi, cj);
            wait_result("b2b", er, ei, t_now);
            if (i > 0) chk("b2b_spacing", t_now - t_prev, 6);
            t_prev = t_now;
        end
        @(posedge clk_in); #1;
        chk("b2b_final_pulse", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cmul_mac_sched.md
# cmul_mac_sched

Time-shared complex multiplier controller. It accepts one complex sample and one complex coefficient per transaction and sequences four real 16x14 signed multiplies through a single multiply-accumulate unit. That unit has a registered product with clock enable (CEM) and an add/subtract accumulator. The block sits in the front-end mixing/filtering datapath wherever one MAC slice must replace four multipliers, and returns an exact complex product through a valid/ready output.

## Interface
- A_W, 16, sample component width (signed)
- B_W, 14, coefficient component width (signed)
- P_W, A_W+B_W+1, output component width (exact, no saturation)
- CLK_IN  in  1  single clock, rising edge
- RST_N_IN  in  1  reset, asynchronous and active-low
- IN_VALID  in  1  operand transaction valid
- IN_READY  out  1  block can accept a transaction
- A_RE_IN, A_IM_IN  in  A_W each  sample real/imag, signed
- B_RE_IN, B_IM_IN  in  B_W each  coefficient real/imag, signed
- CONJ_IN  in  1  1: multiply by conj(B); sampled with operands
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  downstream accepts result
- P_RE_OUT, P_IM_OUT  out  P_W each  result real/imag, signed
- BUSY_OUT  out  1  state != IDLE

## Operation
- Accept occurs when IN_VALID & IN_READY at a rising edge. On accept, all four operands and CONJ_IN are latched. Inputs are ignored otherwise.
- IN_READY = (state==IDLE) & (!OUT_VALID | OUT_READY).
- States: IDLE -> S_RR -> S_II -> S_RI -> S_IR -> S_ACC -> IDLE, unconditional after accept.
- S_RR: multiplier operands are a_re,b_re; CEM=1; M <= a_re*b_re.
- S_II: M <= a_im*b_im; P <= M.
- S_RI: M <= a_re*b_im; P <= P - M, or P + M if conj. P now holds re.
- S_IR: M <= a_im*b_re; RE_Q <= P; P <= M.
- S_ACC: CEM=0; P_IM_OUT <= M + P if !conj, or M - P if conj (conj: im = a_im*b_re - a_re*b_im); P_RE_OUT <= RE_Q; OUT_VALID <= 1.
- Arithmetic: products are exact A_W+B_W signed, sign-extended to P_W before add/sub. No rounding or saturation; P_W cannot overflow.
- OUT_VALID clears on OUT_VALID & OUT_READY unless S_ACC sets it the same edge. S_ACC cannot coincide with a pending result because of the IN_READY rule.
- Result outputs hold stable while OUT_VALID=1 and OUT_READY=0.

## Timing
- Reset (async assert, sync release) sets: state IDLE, OUT_VALID=0, P_RE_OUT=0, P_IM_OUT=0, BUSY_OUT=0, M=P=RE_Q=0. IN_READY=1 after reset.
- Latency: accept at edge 0, OUT_VALID visible after edge 5.
- Throughput: one transaction per 6 cycles when OUT_READY=1. The result-accept edge can also accept the next transaction.
- BUSY_OUT is high for the 5 cycles S_RR..S_ACC.
- Reset mid-transaction discards the partial result; no OUT_VALID is produced for it.
- Backpressure: the block stalls in IDLE with IN_READY=0 until the result drains. The MAC is idle (CEM=0) while stalled.

## Structure
- Package cmul_sched_pkg holds:
  - state enum (IDLE, S_RR, S_II, S_RI, S_IR, S_ACC)
  - default widths A_W/B_W/P_W
  - operand-select encoding (SEL_RR, SEL_II, SEL_RI, SEL_IR)
  - accumulator opcode (ACC_LOAD, ACC_ADD, ACC_SUB, ACC_HOLD)
- Sub-module cmul_mac_core contains:
  - signed A_W x B_W multiplier with M register gated by CEM (MREG=1 behaviour)
  - P_W accumulator register driven by the opcode
  - no FSM logic
- The top level contains the FSM, operand latch/mux, RE_Q, and output registers.

## Test plan
- Basic: A=(3,4), B=(5,2), CONJ=0, OUT_READY=1 -> P=(7,26); OUT_VALID exactly 5 edges after accept, for 1 cycle.
- Conjugate: A=(3,4), B=(5,2), CONJ=1 -> P=(23,14).
- Extremes: A=(-32768,-32768), B=(-8192,8191) -> P=(536838144,32768), with no wrap.
- Backpressure: OUT_READY=0 for 10 cycles after the result with IN_VALID=1 held -> outputs stable, IN_READY=0. On OUT_READY=1, the next transaction is accepted on the same edge.
- Back-to-back: 8 random transactions with OUT_READY=1 -> results match the reference model in order, spaced exactly 6 cycles.
- Reset mid-op: assert RST_N_IN=0 in S_RI -> all outputs 0 immediately. After release, IN_READY=1, no stale OUT_VALID, and the next transaction is correct.
